// File: rtl/multicycle_adder_core.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_adder_core
// Brief    : Bit-serial / slice-serial adder-subtractor, SLICE bits per cycle
//            with a registered inter-slice carry and start/busy/done handshake.
//            Optional signed-overflow output v_out under ADDER_OVERFLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_adder_core #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  input  logic             in_sub,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             v_out
`endif
);

  localparam int c_n     = WIDTH / SLICE;
  localparam int c_idx_w = (c_n > 1) ? $clog2(c_n) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_n - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic [c_idx_w-1:0] r_idx;

  logic [SLICE:0]     w_slice;
  logic [WIDTH-1:0]   w_sum_next;
`ifdef ADDER_OVERFLOW_EN
  logic               w_cin_msb;
`endif

  always_comb begin
    w_slice    = {1'b0, r_a[SLICE-1:0]} + {1'b0, r_b[SLICE-1:0]} + {{SLICE{1'b0}}, r_carry};
    // New slice enters at the top so after c_n slices the LSB slice sits at bit 0.
    w_sum_next = (r_sum >> SLICE) | (WIDTH'(w_slice[SLICE-1:0]) << (WIDTH - SLICE));
`ifdef ADDER_OVERFLOW_EN
    // Carry into the MSB, recovered from the MSB sum bit of the current slice.
    w_cin_msb  = r_a[SLICE-1] ^ r_b[SLICE-1] ^ w_slice[SLICE-1];
`endif
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      out_busy <= 1'b0;
      out_done <= 1'b0;
      s_out    <= '0;
      c_out    <= 1'b0;
`ifdef ADDER_OVERFLOW_EN
      v_out    <= 1'b0;
`endif
    end else begin
      out_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_start) begin
            r_a      <= in_a;
            r_b      <= in_sub ? ~in_b : in_b;
            r_carry  <= in_c ^ in_sub;
            r_idx    <= '0;
            out_busy <= 1'b1;
            r_state  <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum   <= w_sum_next;
          r_a     <= r_a >> SLICE;
          r_b     <= r_b >> SLICE;
          r_carry <= w_slice[SLICE];
          r_idx   <= r_idx + 1'b1;
          // Results are loaded on the final slice edge so they are visible
          // for the whole DONE cycle alongside the done pulse.
          if (r_idx == c_last_idx) begin
            r_state  <= S_DONE;
            out_busy <= 1'b0;
            out_done <= 1'b1;
            s_out    <= w_sum_next;
            c_out    <= w_slice[SLICE];
`ifdef ADDER_OVERFLOW_EN
            v_out    <= w_cin_msb ^ w_slice[SLICE];
`endif
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_adder_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_adder_core
// Brief    : Self-checking bench; SLICE=1 and SLICE=4 instances at WIDTH=8,
//            checked against an integer-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_adder_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       st0 = 1'b0;
  logic       st1 = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       c_in = 1'b0;
  logic       sub = 1'b0;

  logic       busy0, done0, c0, busy1, done1, c1;
  logic [7:0] s0, s1;
  logic       v0, v1;

  int total = 0;
  int bad = 0;
  logic [7:0] prev_s [2];
  logic       prev_c [2];
  logic       prev_v [2];

  always #5 clk = ~clk;

  multicycle_adder_core #(.WIDTH(8), .SLICE(1)) u_dut1 (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(st0), .in_a(a), .in_b(b),
    .in_c(c_in), .in_sub(sub), .out_busy(busy0), .out_done(done0),
    .s_out(s0), .c_out(c0)
`ifdef ADDER_OVERFLOW_EN
    , .v_out(v0)
`endif
  );

  multicycle_adder_core #(.WIDTH(8), .SLICE(4)) u_dut4 (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(st1), .in_a(a), .in_b(b),
    .in_c(c_in), .in_sub(sub), .out_busy(busy1), .out_done(done1),
    .s_out(s1), .c_out(c1)
`ifdef ADDER_OVERFLOW_EN
    , .v_out(v1)
`endif
  );

`ifndef ADDER_OVERFLOW_EN
  assign v0 = 1'b0;
  assign v1 = 1'b0;
`endif

  function automatic logic g_busy(int sel); return sel != 0 ? busy1 : busy0; endfunction
  function automatic logic g_done(int sel); return sel != 0 ? done1 : done0; endfunction
  function automatic logic [7:0] g_s(int sel); return sel != 0 ? s1 : s0; endfunction
  function automatic logic g_c(int sel); return sel != 0 ? c1 : c0; endfunction
  function automatic logic g_v(int sel); return sel != 0 ? v1 : v0; endfunction

  // Reference: plain integer add/subtract; returns {v, c, s[7:0]}.
  function automatic logic [9:0] model(logic [7:0] ma, logic [7:0] mb, logic mc, logic msub);
    int u, sr;
    logic [9:0] r;
    if (!msub) begin
      u  = int'(ma) + int'(mb) + int'(mc);
      sr = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
      r[8] = (u > 255);
    end else begin
      u  = int'(ma) - int'(mb) - int'(mc);
      sr = int'($signed(ma)) - int'($signed(mb)) - int'(mc);
      r[8] = (u >= 0);
    end
    r[7:0] = 8'(u);
    r[9]   = (sr > 127) || (sr < -128);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) st1 = v; else st0 = v;
  endtask

  // One operation; poke pulses in_start during ADD (cycle 3) and in DONE.
  task automatic run_op(input int sel, input logic [7:0] ia, input logic [7:0] ib,
                        input logic ic, input logic isub, input bit poke);
    int n;
    logic [9:0] m;
    n = (sel != 0) ? 2 : 8;
    m = model(ia, ib, ic, isub);
    @(negedge clk);
    a = ia; b = ib; c_in = ic; sub = isub;
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    for (int i = 0; i < n; i++) begin
      chk("busy_during_add", 32'(g_busy(sel)), 32'd1);
      chk("no_early_done", 32'(g_done(sel)), 32'd0);
      chk("s_hold_in_add", 32'(g_s(sel)), 32'(prev_s[sel]));
      chk("c_hold_in_add", 32'(g_c(sel)), 32'(prev_c[sel]));
      a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      if (poke && i == 2) begin a = 8'hF0; b = 8'h0F; end
      set_start(sel, poke && i == 2);
      @(negedge clk);
    end
    set_start(sel, 1'b0);
    chk("done_pulse", 32'(g_done(sel)), 32'd1);
    chk("busy_clear", 32'(g_busy(sel)), 32'd0);
    chk("s_out", 32'(g_s(sel)), 32'(m[7:0]));
    chk("c_out", 32'(g_c(sel)), 32'(m[8]));
`ifdef ADDER_OVERFLOW_EN
    chk("v_out", 32'(g_v(sel)), 32'(m[9]));
`endif
    prev_s[sel] = m[7:0];
    prev_c[sel] = m[8];
    prev_v[sel] = m[9];
    if (poke) begin a = 8'hF0; b = 8'h0F; set_start(sel, 1'b1); end
    @(negedge clk);
    set_start(sel, 1'b0);
    chk("done_single_cycle", 32'(g_done(sel)), 32'd0);
    chk("s_hold_after_done", 32'(g_s(sel)), 32'(prev_s[sel]));
    if (poke) begin
      @(negedge clk);
      chk("start_in_done_ignored", 32'(g_busy(sel)), 32'd0);
      chk("s_hold_idle", 32'(g_s(sel)), 32'(prev_s[sel]));
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin prev_s[i] = '0; prev_c[i] = 1'b0; prev_v[i] = 1'b0; end

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int sel = 0; sel < 2; sel++) begin
      chk("rst_busy", 32'(g_busy(sel)), 32'd0);
      chk("rst_done", 32'(g_done(sel)), 32'd0);
      chk("rst_s", 32'(g_s(sel)), 32'd0);
      chk("rst_c", 32'(g_c(sel)), 32'd0);
      chk("rst_v", 32'(g_v(sel)), 32'd0);
    end
    rst_n = 1'b1;

    // Directed cases
    run_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op(0, 8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
    run_op(0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0);
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
    run_op(1, 8'h9C, 8'h78, 1'b0, 1'b0, 1'b0);
    run_op(1, 8'h80, 8'h01, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of an operation
    @(negedge clk);
    a = 8'h33; b = 8'h44; c_in = 1'b0; sub = 1'b0; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_done", 32'(done0), 32'd0);
    chk("midrst_s", 32'(s0), 32'd0);
    chk("midrst_c", 32'(c0), 32'd0);
    chk("midrst_v", 32'(v0), 32'd0);
    prev_s[0] = '0; prev_c[0] = 1'b0; prev_v[0] = 1'b0;
    prev_s[1] = '0; prev_c[1] = 1'b0; prev_v[1] = 1'b0;
    begin
      int dseen;
      dseen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (done0 !== 1'b0) dseen++;
      end
      chk("midrst_no_done", 32'(dseen), 32'd0);
    end
    run_op(0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

    // Randomized operations on both slice widths
    for (int i = 0; i < 24; i++) begin
      run_op(i % 2, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
